// File: rtl/iecdrv_sd_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : iecdrv_pkg                                                   |
// | Description : Shared types and helpers for the IEC multi-drive wrapper and |
// |               its SD channel arbiter: arbiter state encoding, the drive    |
// |               count limit and the drive-count clamp.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package iecdrv_pkg;

    localparam int MAX_DRIVES = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_XFER  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_t;

    // Drive count forced into 1..MAX_DRIVES so out-of-range parameters
    // still elaborate to a working configuration.
    function automatic int clamp_ndr(input int n);
        if (n < 1) begin
            return 1;
        end
        if (n > MAX_DRIVES) begin
            return MAX_DRIVES;
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iecdrv_sd_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : iecdrv_sd_arbiter_if                                         |
// | Description : Bundles the per-drive request side and the host SD block     |
// |               channel side of the arbiter.                                 |
// |   drv_lba/drv_rd/drv_wr/drv_buff_din : per-drive requests (to arbiter)     |
// |   drv_ack                            : per-drive ack (from arbiter)        |
// |   sd_lba/sd_rd/sd_wr/sd_buff_din     : host request side (from arbiter)    |
// |   sd_ack                             : host ack (to arbiter)               |
// |   modport master : arbiter view; modport slave : drives + host view        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface iecdrv_sd_arbiter_if #(
    parameter int NDR = 2
);
    localparam int c_N = iecdrv_pkg::clamp_ndr(NDR);

    logic [c_N-1:0][31:0] drv_lba;
    logic [c_N-1:0]       drv_rd;
    logic [c_N-1:0]       drv_wr;
    logic [c_N-1:0]       drv_ack;
    logic [c_N-1:0][7:0]  drv_buff_din;

    logic [31:0]          sd_lba;
    logic                 sd_rd;
    logic                 sd_wr;
    logic                 sd_ack;
    logic [7:0]           sd_buff_din;

    modport master (
        input  drv_lba, drv_rd, drv_wr, drv_buff_din, sd_ack,
        output drv_ack, sd_lba, sd_rd, sd_wr, sd_buff_din
    );

    modport slave (
        output drv_lba, drv_rd, drv_wr, drv_buff_din, sd_ack,
        input  drv_ack, sd_lba, sd_rd, sd_wr, sd_buff_din
    );

endinterface
`default_nettype wire

// File: rtl/iecdrv_sd_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : iecdrv_rr_pick                                               |
// | Description : Combinational round-robin picker. Returns the first pending  |
// |               index strictly after the last-grant pointer, wrapping        |
// |               modulo N.                                                    |
// |   i_pending : pending requests (bits >= N must be zero)                    |
// |   i_last    : last-grant pointer                                           |
// |   o_valid   : at least one request pending                                 |
// |   o_idx     : chosen drive index                                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module iecdrv_rr_pick
    import iecdrv_pkg::*;
#(
    parameter int N = 2
) (
    input  wire logic [MAX_DRIVES-1:0] i_pending,
    input  wire logic [1:0]            i_last,
    output logic                       o_valid,
    output logic [1:0]                 o_idx
);

    localparam int c_N = clamp_ndr(N);

    // Scan from the farthest offset to the nearest so the nearest pending
    // index after the pointer is the last one written and therefore wins.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = 2'd0;
        for (int off = c_N; off >= 1; off--) begin
            if (i_pending[2'((int'(i_last) + off) % c_N)]) begin
                o_valid = 1'b1;
                o_idx   = 2'((int'(i_last) + off) % c_N);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/iecdrv_sd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : iecdrv_sd_arbiter                                            |
// | Description : Shares one host SD block channel among up to four IEC drive  |
// |               instances. Grants are round-robin; host ack and write data   |
// |               are routed to/from the granted drive only.                   |
// |   clk   : clk_sys                                                          |
// |   reset : asynchronous, active-high                                        |
// |   bus   : drive request side + host SD side (master modport)               |
// |   grant : index of the current / last granted drive                        |
// |   busy  : arbiter is not idle                                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module iecdrv_sd_arbiter
    import iecdrv_pkg::*;
#(
    parameter int NDR   = 2,
    parameter int TMO_W = 24
) (
    input  wire logic            clk,
    input  wire logic            reset,
    iecdrv_sd_arbiter_if.master  bus,
    output logic [1:0]           grant,
    output logic                 busy
);

    localparam int               c_N        = clamp_ndr(NDR);
    localparam logic [1:0]       c_PTR_RST  = 2'(c_N - 1);
    // Abort when the counter is one step from all-ones, i.e. the request
    // has been held for 2^TMO_W-1 cycles.
    localparam logic [TMO_W-1:0] c_TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
    localparam logic [TMO_W-1:0] c_TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};

    arb_state_t       state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [31:0]      sd_lba_q, sd_lba_d;
    logic             sd_rd_q, sd_rd_d;
    logic             sd_wr_q, sd_wr_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Drive-side vectors padded to MAX_DRIVES so a 2-bit grant always
    // indexes in range regardless of NDR.
    logic [MAX_DRIVES-1:0]       w_rd4;
    logic [MAX_DRIVES-1:0]       w_wr4;
    logic [MAX_DRIVES-1:0]       w_pend4;
    logic [MAX_DRIVES-1:0][31:0] w_lba4;
    logic [MAX_DRIVES-1:0][7:0]  w_din4;
    logic                        w_pick_valid;
    logic [1:0]                  w_pick_idx;
    logic                        w_ack_en;

    for (genvar g = 0; g < MAX_DRIVES; g++) begin : g_pad
        if (g < c_N) begin : g_used
            assign w_rd4[g]  = bus.drv_rd[g];
            assign w_wr4[g]  = bus.drv_wr[g];
            assign w_lba4[g] = bus.drv_lba[g];
            assign w_din4[g] = bus.drv_buff_din[g];
        end else begin : g_unused
            assign w_rd4[g]  = 1'b0;
            assign w_wr4[g]  = 1'b0;
            assign w_lba4[g] = 32'd0;
            assign w_din4[g] = 8'd0;
        end
    end

    assign w_pend4 = w_rd4 | w_wr4;

    iecdrv_rr_pick #(
        .N (c_N)
    ) u_pick (
        .i_pending (w_pend4),
        .i_last    (ptr_q),
        .o_valid   (w_pick_valid),
        .o_idx     (w_pick_idx)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            grant_q  <= 2'd0;
            ptr_q    <= c_PTR_RST;
            sd_lba_q <= 32'd0;
            sd_rd_q  <= 1'b0;
            sd_wr_q  <= 1'b0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            sd_lba_q <= sd_lba_d;
            sd_rd_q  <= sd_rd_d;
            sd_wr_q  <= sd_wr_d;
            tmo_q    <= tmo_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        sd_lba_d = sd_lba_q;
        sd_rd_d  = sd_rd_q;
        sd_wr_d  = sd_wr_q;
        tmo_d    = tmo_q;

        case (state_q)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    grant_d  = w_pick_idx;
                    sd_lba_d = w_lba4[w_pick_idx];
                    // Read wins when a drive raises both directions.
                    sd_rd_d  = w_rd4[w_pick_idx];
                    sd_wr_d  = ~w_rd4[w_pick_idx];
                    tmo_d    = '0;
                    state_d  = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (bus.sd_ack) begin
                    sd_rd_d = 1'b0;
                    sd_wr_d = 1'b0;
                    state_d = ARB_XFER;
                end else if (!w_pend4[grant_q] || (tmo_q == c_TMO_LAST)) begin
                    // Drive abort or host never answered: release the
                    // channel and move the pointer past this drive.
                    sd_rd_d = 1'b0;
                    sd_wr_d = 1'b0;
                    ptr_d   = grant_q;
                    state_d = ARB_IDLE;
                end else begin
                    tmo_d = tmo_q + c_TMO_ONE;
                end
            end
            ARB_XFER: begin
                if (!bus.sd_ack) begin
                    state_d = ARB_DONE;
                end
            end
            ARB_DONE: begin
                ptr_d   = grant_q;
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Output logic: ack and write data are unregistered so they track the
    // host strobes cycle-for-cycle.
    always_comb begin
        w_ack_en        = bus.sd_ack & ((state_q == ARB_ISSUE) | (state_q == ARB_XFER));
        busy            = (state_q != ARB_IDLE);
        bus.sd_buff_din = w_din4[grant_q];
    end

    for (genvar g = 0; g < c_N; g++) begin : g_ack
        assign bus.drv_ack[g] = w_ack_en & (grant_q == 2'(g));
    end

    assign bus.sd_lba = sd_lba_q;
    assign bus.sd_rd  = sd_rd_q;
    assign bus.sd_wr  = sd_wr_q;
    assign grant      = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_iecdrv_sd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_iecdrv_sd_arbiter                                         |
// | Description : Self-checking bench for iecdrv_sd_arbiter (NDR=4, short      |
// |               timeout) with directed scenarios and a randomized run        |
// |               against a round-robin reference model.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_iecdrv_sd_arbiter;

    localparam int c_NDR   = 4;
    localparam int c_TMO_W = 6;
    localparam int c_TMO_CYC = (1 << c_TMO_W) - 1;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] grant;
    logic       busy;

    iecdrv_sd_arbiter_if #(.NDR(c_NDR)) bus ();

    iecdrv_sd_arbiter #(
        .NDR   (c_NDR),
        .TMO_W (c_TMO_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .grant (grant),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          last_m;
    bit [3:0]    pend_m;
    logic [31:0] lba_m [4];
    logic [7:0]  din_m [4];
    bit          dir_rd_m [4];

    function automatic int model_pick(input bit [3:0] pend, input int last);
        for (int off = 1; off <= c_NDR; off++) begin
            int j;
            j = (last + off) % c_NDR;
            if (pend[j]) return j;
        end
        return -1;
    endfunction

    task automatic clear_inputs();
        bus.drv_rd       = '0;
        bus.drv_wr       = '0;
        bus.drv_lba      = '0;
        bus.drv_buff_din = '0;
        bus.sd_ack       = 1'b0;
        for (int i = 0; i < 4; i++) begin
            lba_m[i] = 32'd0; din_m[i] = 8'd0; dir_rd_m[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b0;
        last_m = c_NDR - 1;
        pend_m = '0;
    endtask

    task automatic raise_req(input int d, input bit rd, input bit wr,
                             input logic [31:0] lba, input logic [7:0] din);
        lba_m[d]    = lba;
        din_m[d]    = din;
        dir_rd_m[d] = rd;
        pend_m[d]   = 1'b1;
        bus.drv_lba[d]      = lba;
        bus.drv_buff_din[d] = din;
        bus.drv_rd[d]       = rd;
        bus.drv_wr[d]       = wr;
    endtask

    task automatic wait_issue(output int n);
        n = 0;
        while (!(bus.sd_rd || bus.sd_wr) && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Host holds ack for len cycles; the drive drops its request once it
    // has seen ack. Counts cycles with the expected ack vector and data.
    task automatic host_ack(input int d, input int len, output int ack_ok, output int din_ok);
        ack_ok = 0;
        din_ok = 0;
        bus.sd_ack = 1'b1;
        for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 1) begin
                bus.drv_rd[d] = 1'b0;
                bus.drv_wr[d] = 1'b0;
            end
            #1;
            if (bus.drv_ack === 4'(1 << d)) ack_ok++;
            if (bus.sd_buff_din === din_m[d]) din_ok++;
        end
        @(negedge clk);
        bus.sd_ack    = 1'b0;
        bus.drv_rd[d] = 1'b0;
        bus.drv_wr[d] = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.sd_rd, bus.sd_wr, bus.drv_ack, grant, busy} !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rd=%b wr=%b ack=%b grant=%0d busy=%b required all 0",
                     bus.sd_rd, bus.sd_wr, bus.drv_ack, grant, busy);
        end
        checks++;
        if (bus.sd_lba !== 32'd0) begin
            errors++;
            $display("FAIL reset_lba: got %h required 0", bus.sd_lba);
        end
        reset  = 1'b0;
        last_m = c_NDR - 1;
        pend_m = '0;
    endtask

    task automatic test_single_read();
        int ack_cnt;
        do_reset();
        raise_req(0, 1'b1, 1'b0, 32'h0000_0123, 8'h00);
        @(negedge clk);
        checks++;
        if ({bus.sd_rd, bus.sd_wr, grant, busy} !== 5'b10_00_1) begin
            errors++;
            $display("FAIL single_issue: got rd=%b wr=%b grant=%0d busy=%b required rd=1 wr=0 grant=0 busy=1",
                     bus.sd_rd, bus.sd_wr, grant, busy);
        end
        checks++;
        if (bus.sd_lba !== 32'h0000_0123) begin
            errors++;
            $display("FAIL single_lba: got %h required 00000123", bus.sd_lba);
        end
        bus.sd_ack = 1'b1;
        ack_cnt = 0;
        for (int i = 0; i < 512; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 1) begin
                checks++;
                if (bus.sd_rd !== 1'b0) begin
                    errors++;
                    $display("FAIL single_rd_clear: got %b required 0", bus.sd_rd);
                end
                bus.drv_rd[0] = 1'b0;
            end
            #1;
            if (bus.drv_ack === 4'b0001) ack_cnt++;
        end
        @(negedge clk);
        bus.sd_ack = 1'b0;
        #1;
        checks++;
        if (bus.drv_ack !== 4'b0000) begin
            errors++;
            $display("FAIL single_ack_off: got %b required 0000", bus.drv_ack);
        end
        checks++;
        if (ack_cnt !== 512) begin
            errors++;
            $display("FAIL single_ack_len: got %0d required 512", ack_cnt);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_dual_rd();
        int a, dn;
        do_reset();
        raise_req(0, 1'b1, 1'b0, 32'h0000_000A, 8'h11);
        raise_req(1, 1'b1, 1'b0, 32'h0000_000B, 8'h22);
        @(negedge clk);
        checks++;
        if (grant !== 2'd0 || bus.sd_lba !== 32'h0000_000A) begin
            errors++;
            $display("FAIL dual_first: got grant=%0d lba=%h required grant=0 lba=0000000a", grant, bus.sd_lba);
        end
        host_ack(0, 8, a, dn);
        checks++;
        if (a !== 8) begin
            errors++;
            $display("FAIL dual_ack0: got %0d required 8", a);
        end
        @(negedge clk);
        checks++;
        if (bus.sd_rd !== 1'b0) begin
            errors++;
            $display("FAIL dual_gap1: got sd_rd=%b required 0", bus.sd_rd);
        end
        @(negedge clk);
        checks++;
        if (bus.sd_rd !== 1'b0) begin
            errors++;
            $display("FAIL dual_gap2: got sd_rd=%b required 0", bus.sd_rd);
        end
        @(negedge clk);
        checks++;
        if (bus.sd_rd !== 1'b1 || grant !== 2'd1 || bus.sd_lba !== 32'h0000_000B) begin
            errors++;
            $display("FAIL dual_second: got rd=%b grant=%0d lba=%h required rd=1 grant=1 lba=0000000b",
                     bus.sd_rd, grant, bus.sd_lba);
        end
        host_ack(1, 3, a, dn);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_fair4();
        int n, exp, a, dn;
        do_reset();
        for (int d = 0; d < 4; d++) raise_req(d, 1'b1, 1'b0, 32'(d * 256), 8'(d));
        for (int k = 0; k < 6; k++) begin
            wait_issue(n);
            exp = model_pick(pend_m, last_m);
            checks++;
            if (n >= 200 || int'(grant) !== exp) begin
                errors++;
                $display("FAIL fair_grant[%0d]: got %0d required %0d (wait %0d)", k, grant, exp, n);
            end
            host_ack(exp, 4, a, dn);
            checks++;
            if (a !== 4) begin
                errors++;
                $display("FAIL fair_ack[%0d]: got %0d required 4", k, a);
            end
            last_m = exp;
            if (k < 5) bus.drv_rd[exp] = 1'b1;
        end
        bus.drv_rd = '0;
        pend_m = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write_mux();
        int a, dn;
        do_reset();
        din_m[0] = 8'h3C;
        bus.drv_buff_din[0] = 8'h3C;
        raise_req(1, 1'b0, 1'b1, 32'h0000_0777, 8'hA5);
        @(negedge clk);
        checks++;
        if ({bus.sd_rd, bus.sd_wr, grant} !== 4'b01_01) begin
            errors++;
            $display("FAIL wr_issue: got rd=%b wr=%b grant=%0d required rd=0 wr=1 grant=1",
                     bus.sd_rd, bus.sd_wr, grant);
        end
        checks++;
        if (bus.sd_buff_din !== 8'hA5 || bus.drv_ack !== 4'b0000) begin
            errors++;
            $display("FAIL wr_premux: got din=%h ack=%b required din=a5 ack=0000", bus.sd_buff_din, bus.drv_ack);
        end
        host_ack(1, 16, a, dn);
        checks++;
        if (a !== 16) begin
            errors++;
            $display("FAIL wr_ack: got %0d required 16", a);
        end
        checks++;
        if (dn !== 16) begin
            errors++;
            $display("FAIL wr_din: got %0d required 16", dn);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_abort();
        int a, dn;
        do_reset();
        raise_req(0, 1'b1, 1'b0, 32'h0000_0100, 8'h00);
        raise_req(1, 1'b1, 1'b0, 32'h0000_0200, 8'h00);
        @(negedge clk);
        checks++;
        if (grant !== 2'd0 || bus.sd_rd !== 1'b1) begin
            errors++;
            $display("FAIL abort_first: got grant=%0d rd=%b required grant=0 rd=1", grant, bus.sd_rd);
        end
        bus.drv_rd[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.sd_rd !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_release: got rd=%b busy=%b required rd=0 busy=0", bus.sd_rd, busy);
        end
        @(negedge clk);
        checks++;
        if (bus.sd_rd !== 1'b1 || grant !== 2'd1) begin
            errors++;
            $display("FAIL abort_next: got rd=%b grant=%0d required rd=1 grant=1", bus.sd_rd, grant);
        end
        host_ack(1, 2, a, dn);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_timeout();
        int n, hi, lo;
        do_reset();
        raise_req(2, 1'b1, 1'b0, 32'h0000_0300, 8'h00);
        wait_issue(n);
        checks++;
        if (n >= 200 || grant !== 2'd2) begin
            errors++;
            $display("FAIL tmo_issue: got grant=%0d wait=%0d required grant=2", grant, n);
        end
        hi = 0;
        while (bus.sd_rd && hi < 200) begin
            hi++;
            @(negedge clk);
        end
        checks++;
        if (hi !== c_TMO_CYC) begin
            errors++;
            $display("FAIL tmo_len: got %0d cycles required %0d", hi, c_TMO_CYC);
        end
        lo = 0;
        while (!bus.sd_rd && lo < 10) begin
            lo++;
            @(negedge clk);
        end
        checks++;
        if (lo !== 1) begin
            errors++;
            $display("FAIL tmo_reissue_gap: got %0d required 1", lo);
        end
        bus.drv_rd[2] = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL tmo_drop: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_spurious_ack();
        int ok;
        do_reset();
        ok = 0;
        bus.sd_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.drv_ack === 4'b0000 && busy === 1'b0) ok++;
        end
        bus.sd_ack = 1'b0;
        checks++;
        if (ok !== 6) begin
            errors++;
            $display("FAIL spurious_ack: got %0d clean cycles required 6", ok);
        end
    endtask

    task automatic test_async_reset();
        int a, dn;
        do_reset();
        raise_req(0, 1'b1, 1'b0, 32'h0000_0010, 8'h00);
        @(negedge clk);
        host_ack(0, 4, a, dn);
        repeat (2) @(negedge clk);
        raise_req(1, 1'b1, 1'b0, 32'h0000_0020, 8'h00);
        @(negedge clk);
        checks++;
        if (grant !== 2'd1 || bus.sd_rd !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre: got grant=%0d rd=%b required grant=1 rd=1", grant, bus.sd_rd);
        end
        bus.sd_ack = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.sd_rd, bus.sd_wr, bus.drv_ack, busy, grant} !== 9'd0) begin
            errors++;
            $display("FAIL arst_immediate: got rd=%b wr=%b ack=%b busy=%b grant=%0d required all 0",
                     bus.sd_rd, bus.sd_wr, bus.drv_ack, busy, grant);
        end
        @(negedge clk);
        bus.sd_ack = 1'b0;
        bus.drv_rd = 4'b0011;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (grant !== 2'd0 || bus.sd_rd !== 1'b1) begin
            errors++;
            $display("FAIL arst_after: got grant=%0d rd=%b required grant=0 rd=1", grant, bus.sd_rd);
        end
    endtask

    task automatic test_random();
        int n, exp, a, dn, len, r;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            for (int d = 0; d < 4; d++) begin
                if (!pend_m[d] && $urandom_range(0, 1) == 1) begin
                    r = $urandom_range(0, 2);
                    raise_req(d, r != 1, r != 0, $urandom, 8'($urandom));
                end
            end
            if (pend_m == 4'b0000) begin
                r = $urandom_range(0, 3);
                raise_req(r, 1'b0, 1'b1, $urandom, 8'($urandom));
            end
            wait_issue(n);
            exp = model_pick(pend_m, last_m);
            checks++;
            if (n >= 200 || int'(grant) !== exp) begin
                errors++;
                $display("FAIL rnd_grant[%0d]: got %0d required %0d (wait %0d)", it, grant, exp, n);
            end
            checks++;
            if (bus.sd_lba !== lba_m[exp]) begin
                errors++;
                $display("FAIL rnd_lba[%0d]: got %h required %h", it, bus.sd_lba, lba_m[exp]);
            end
            checks++;
            if ({bus.sd_rd, bus.sd_wr} !== (dir_rd_m[exp] ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL rnd_dir[%0d]: got rd=%b wr=%b required rd=%b", it, bus.sd_rd, bus.sd_wr, dir_rd_m[exp]);
            end
            repeat ($urandom_range(0, 4)) @(negedge clk);
            if ($urandom_range(0, 4) == 0) begin
                bus.drv_rd[exp] = 1'b0;
                bus.drv_wr[exp] = 1'b0;
                @(negedge clk);
                checks++;
                if (bus.sd_rd !== 1'b0 || bus.sd_wr !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_abort[%0d]: got rd=%b wr=%b required 0 0", it, bus.sd_rd, bus.sd_wr);
                end
            end else begin
                len = $urandom_range(1, 12);
                host_ack(exp, len, a, dn);
                checks++;
                if (a !== len || dn !== len) begin
                    errors++;
                    $display("FAIL rnd_xfer[%0d]: got ack=%0d din=%0d required %0d", it, a, dn, len);
                end
            end
            pend_m[exp] = 1'b0;
            last_m = exp;
        end
        bus.drv_rd = '0;
        bus.drv_wr = '0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_dual_rd();
        test_fair4();
        test_write_mux();
        test_abort();
        test_timeout();
        test_spurious_ack();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
